timer_seq_ctrl: RTL and testbench

Programmable interval-timer controller that sequences a 32-bit loadable up/down counter.
- Register interface sets the reload value, direction, one-shot/periodic mode and interrupt enable.
- An FSM loads the counter, runs it, detects terminal count, flags expiry, and in periodic mode reloads it.
- Sits between the CPU-side register bus and the counter datapath; drives an interrupt line to the system.

---
 rtl/timer_seq_ctrl_pkg.sv | 29 ++
 rtl/timer_seq_ctrl_cnt_dp.sv | 42 ++++
 rtl/timer_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_timer_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_ctrl_pkg.sv
// Shared register map, CTRL bit positions and FSM state encoding for the
// interval-timer controller.
package timer_seq_ctrl_pkg;

  localparam logic [1:0] ADDR_LOAD   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_DIR      = 1;
  localparam int unsigned CTRL_PERIODIC = 2;
  localparam int unsigned CTRL_IE       = 3;
  localparam int unsigned CTRL_STOP     = 4;

  localparam int unsigned STATUS_EXPIRED = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_EXPIRE = 2'd3
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/timer_seq_ctrl_cnt_dp.sv
// Loadable up/down counter that saturates at its terminal value
// (0 counting down, all-ones counting up).
module timer_cnt_dp
  import timer_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] cnt,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  assign at_term = up ? (cnt_q == '1) : (cnt_q == '0);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = pdata;
    end else if (en && !at_term) begin
      cnt_d = up ? cnt_q + ONE : cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Interval-timer controller: register file, sequencing FSM and interrupt
// level around the timer_cnt_dp counter datapath.
module timer_seq_ctrl
  import timer_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RELOAD_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             irq
);

  localparam logic [1:0] GAP_LAST = 2'(RELOAD_GAP - 1);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] load_d, load_q;
  logic             dir_d, dir_q;
  logic             per_d, per_q;
  logic             ie_d, ie_q;
  logic             dir_act_d, dir_act_q;
  logic             expired_d, expired_q;
  logic             busy_d, busy_q;
  logic [1:0]       gap_d, gap_q;

  logic             wr_ctrl, start_wr, stop_wr;
  logic             dp_load, dp_en, at_term;

  assign wr_ctrl  = we && (addr == ADDR_CTRL);
  assign start_wr = wr_ctrl && wdata[CTRL_START];
  assign stop_wr  = wr_ctrl && wdata[CTRL_STOP];

  timer_cnt_dp #(
    .WIDTH (WIDTH)
  ) u_cnt_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (dp_load),
    .en      (dp_en),
    .up      (dir_act_q),
    .pdata   (load_q),
    .cnt     (cnt),
    .at_term (at_term)
  );

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    dir_d     = dir_q;
    per_d     = per_q;
    ie_d      = ie_q;
    dir_act_d = dir_act_q;
    expired_d = expired_q;
    gap_d     = gap_q;
    dp_load   = 1'b0;
    dp_en     = 1'b0;

    if (we && (addr == ADDR_LOAD)) begin
      load_d = wdata;
    end
    if (wr_ctrl) begin
      dir_d = wdata[CTRL_DIR];
      per_d = wdata[CTRL_PERIODIC];
      ie_d  = wdata[CTRL_IE];
    end
    if (we && (addr == ADDR_STATUS) && wdata[STATUS_EXPIRED]) begin
      expired_d = 1'b0;
    end

    // Command strobes pre-empt the sequencer: the counter freezes and no
    // expiry is recorded on the cycle a stop or restart is taken.
    if (stop_wr) begin
      state_d = ST_IDLE;
    end else if (start_wr) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          dp_load   = 1'b1;
          dir_act_d = dir_q;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          dp_en = 1'b1;
          if (at_term) begin
            expired_d = 1'b1;
            gap_d     = '0;
            state_d   = ST_EXPIRE;
          end
        end
        ST_EXPIRE: begin
          if (gap_q == GAP_LAST) begin
            state_d = per_q ? ST_LOAD : ST_IDLE;
          end else begin
            gap_d = gap_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      load_q    <= '0;
      dir_q     <= 1'b0;
      per_q     <= 1'b0;
      ie_q      <= 1'b0;
      dir_act_q <= 1'b0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      dir_q     <= dir_d;
      per_q     <= per_d;
      ie_q      <= ie_d;
      dir_act_q <= dir_act_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_LOAD: rdata = load_q;
      ADDR_CTRL: begin
        rdata[CTRL_DIR]      = dir_q;
        rdata[CTRL_PERIODIC] = per_q;
        rdata[CTRL_IE]       = ie_q;
      end
      ADDR_STATUS: rdata[STATUS_EXPIRED] = expired_q;
      ADDR_CNT:    rdata = cnt;
      default:     rdata = '0;
    endcase
  end

  assign busy = busy_q;
  assign irq  = expired_q & ie_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed self-checking bench for timer_seq_ctrl.
module tb_timer_seq_ctrl;
  import timer_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [31:0] cnt;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_seq_ctrl #(
    .WIDTH      (32),
    .RELOAD_GAP (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .cnt   (cnt),
    .busy  (busy),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cnt !== 32'd0)  begin errors++; $display("FAIL reset_cnt got %h want 0", cnt); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    addr = ADDR_STATUS; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_status got %h want 0", rdata); end
    @(negedge clk); rst = 1'b0;
    // reset in the middle of a down count
    wr(ADDR_LOAD, 32'd100);
    wr(ADDR_CTRL, 32'd9);
    repeat (20) tick();
    checks++; if (cnt !== 32'd81) begin errors++; $display("FAIL midrun_cnt got %0d want 81", cnt); end
    #2; rst = 1'b1; #1;
    checks++; if (cnt !== 32'd0)  begin errors++; $display("FAIL rst_async_cnt got %h want 0", cnt); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy got %b want 0", busy); end
    addr = ADDR_LOAD; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_async_load got %h want 0", rdata); end
    addr = ADDR_CTRL; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_async_ctrl got %h want 0", rdata); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (irq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got irq=%b busy=%b want 0 0", irq, busy); end
    end
  endtask

  task automatic test_oneshot_down();
    wr(ADDR_LOAD, 32'd5);
    wr(ADDR_CTRL, 32'd9);  // ie | start, edge k
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL os_busy_load got %b want 1", busy); end
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++; if (cnt !== 32'(6 - j)) begin errors++; $display("FAIL os_cnt_k%0d got %0d want %0d", j, cnt, 6 - j); end
    end
    addr = ADDR_STATUS; #1;
    checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL os_expired_early got %b want 0", rdata[0]); end
    tick();
    checks++; if (rdata[0] !== 1'b1) begin errors++; $display("FAIL os_expired got %b want 1", rdata[0]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq got %b want 1", irq); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL os_busy_expire got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_busy_idle got %b want 0", busy); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL os_cnt_hold got %0d want 0", cnt); end
    addr = ADDR_CTRL; #1;
    checks++; if (rdata !== 32'h8) begin errors++; $display("FAIL os_ctrl_read got %h want 8", rdata); end
    wr(ADDR_CNT, 32'd123);
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL cnt_write_ignored got %0d want 0", cnt); end
    wr(ADDR_STATUS, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_periodic_up();
    logic [31:0] exp_cnt [0:10];
    logic        exp_exp [0:10];
    exp_cnt = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFD};
    exp_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    wr(ADDR_LOAD, 32'hFFFFFFFD);
    wr(ADDR_CTRL, 32'd7);  // dir | periodic | start
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 5 || j == 10) begin we = 1'b1; addr = ADDR_STATUS; wdata = 32'd1; end
      @(posedge clk);
      #1;
      we = 1'b0; addr = ADDR_STATUS;
      #1;
      checks++; if (cnt !== exp_cnt[j-1]) begin errors++; $display("FAIL up_cnt_k%0d got %h want %h", j, cnt, exp_cnt[j-1]); end
      checks++; if (rdata[0] !== exp_exp[j-1]) begin errors++; $display("FAIL up_expired_k%0d got %b want %b", j, rdata[0], exp_exp[j-1]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_k%0d got %b want 1", j, busy); end
    end
    wr(ADDR_CTRL, 32'h10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_stop_busy got %b want 0", busy); end
    checks++; if (cnt !== 32'hFFFFFFFD) begin errors++; $display("FAIL up_stop_cnt got %h want fffffffd", cnt); end
  endtask

  task automatic test_load_zero();
    wr(ADDR_LOAD, 32'd0);
    wr(ADDR_CTRL, 32'd1);
    tick();
    addr = ADDR_STATUS; #1;
    checks++; if (cnt !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL zero_run got cnt=%h busy=%b want 0 1", cnt, busy); end
    checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL zero_expired_early got %b want 0", rdata[0]); end
    wr(ADDR_STATUS, 32'd1);  // clear collides with the set
    addr = ADDR_STATUS; #1;
    checks++; if (rdata[0] !== 1'b1) begin errors++; $display("FAIL zero_set_wins got %b want 1", rdata[0]); end
    tick();
    checks++; if (busy !== 1'b0 || rdata[0] !== 1'b1) begin errors++; $display("FAIL zero_idle got busy=%b exp=%b want 0 1", busy, rdata[0]); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL zero_no_wrap got %h want 0", cnt); end
  endtask

  task automatic test_load_change();
    wr(ADDR_STATUS, 32'd1);
    wr(ADDR_LOAD, 32'd10);
    wr(ADDR_CTRL, 32'd5);  // periodic | start, edge k
    repeat (4) tick();
    checks++; if (cnt !== 32'd7) begin errors++; $display("FAIL chg_cnt_k4 got %0d want 7", cnt); end
    wr(ADDR_LOAD, 32'd3);  // edge k+5
    checks++; if (cnt !== 32'd6) begin errors++; $display("FAIL chg_cnt_k5 got %0d want 6", cnt); end
    repeat (6) tick();
    addr = ADDR_STATUS; #1;
    checks++; if (cnt !== 32'd0 || rdata[0] !== 1'b0) begin errors++; $display("FAIL chg_k11 got cnt=%0d exp=%b want 0 0", cnt, rdata[0]); end
    tick();
    checks++; if (rdata[0] !== 1'b1) begin errors++; $display("FAIL chg_expired_k12 got %b want 1", rdata[0]); end
    repeat (2) tick();
    checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL chg_reload_k14 got %0d want 3", cnt); end
    tick();
    checks++; if (cnt !== 32'd2) begin errors++; $display("FAIL chg_cnt_k15 got %0d want 2", cnt); end
    wr(ADDR_CTRL, 32'h10);
    wr(ADDR_STATUS, 32'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] frozen;
    wr(ADDR_LOAD, 32'd20);
    wr(ADDR_CTRL, 32'd1);  // edge k
    repeat (5) tick();
    checks++; if (cnt !== 32'd16) begin errors++; $display("FAIL b2b_cnt_k5 got %0d want 16", cnt); end
    wr(ADDR_CTRL, 32'd1);  // restart while running, edge k+6
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", busy); end
    tick();
    checks++; if (cnt !== 32'd20) begin errors++; $display("FAIL b2b_restart_cnt got %0d want 20", cnt); end
    repeat (13) tick();
    checks++; if (cnt !== 32'd7) begin errors++; $display("FAIL b2b_cnt_before_stop got %0d want 7", cnt); end
    wr(ADDR_CTRL, 32'h11);  // start and stop together
    frozen = cnt;
    checks++; if (cnt !== 32'd7 && cnt !== 32'd6) begin errors++; $display("FAIL stop_cnt got %0d want 6 or 7", cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
    repeat (10) tick();
    addr = ADDR_STATUS; #1;
    checks++; if (cnt !== frozen) begin errors++; $display("FAIL stop_frozen got %0d want %0d", cnt, frozen); end
    checks++; if (rdata[0] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_no_expiry got exp=%b busy=%b want 0 0", rdata[0], busy); end
  endtask

  initial begin
    test_reset();
    test_oneshot_down();
    test_periodic_up();
    test_load_zero();
    test_load_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
